// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and constants for the parking-lot occupancy controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_pkg;

    // Default lot size; the top-level CAPACITY parameter defaults to this.
    localparam int CAPACITY_DEF = 16;

    // Passage-tracking states: EN_* walk outer->inner, EX_* walk inner->outer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_BA = 3'd5,
        EX_A  = 3'd6,
        ABORT = 3'd7
    } state_t;

    // Sensor pair encodings, written {a, b} with 1 = beam blocked.
    localparam logic [1:0] NONE   = 2'b00;
    localparam logic [1:0] B_ONLY = 2'b01;
    localparam logic [1:0] A_ONLY = 2'b10;
    localparam logic [1:0] BOTH   = 2'b11;

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Sensor inputs and occupancy/status outputs of the parking-lot controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface parking_lot_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             sensor_a;
    logic             sensor_b;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             car_enter;
    logic             car_exit;
    logic             count_err;

    // Gate/sensor side drives the photosensors and observes status.
    modport master (
        output sensor_a, sensor_b,
        input  count, full, empty, car_enter, car_exit, count_err
    );

    // Controller side.
    modport slave (
        input  sensor_a, sensor_b,
        output count, full, empty, car_enter, car_exit, count_err
    );
endinterface

// File: rtl/parking_lot_ctrl_sensor_sync.sv
// Two-flop synchronizer for one asynchronous sensor bit.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none.
module sensor_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/parking_lot_ctrl.sv
// Decodes enter/exit passages from gate sensors A (outer) and B (inner) and keeps a saturating occupancy count.
// Latency: count and pulses register one edge after the completing 00 sample (+2 cycles with SENSOR_SYNC_EN).
// Backpressure: none; sensors are sampled every cycle, SENSOR_SYNC_EN adds input synchronizers.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY = CAPACITY_DEF,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    parking_lot_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    logic [1:0]       ab;
    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             enter_q;
    logic             exit_q;
    logic             err_q;

`ifdef SENSOR_SYNC_EN
    logic a_sync;
    logic b_sync;

    sensor_sync u_sync_a (.clk(clk), .reset(reset), .d_i(bus.sensor_a), .q_o(a_sync));
    sensor_sync u_sync_b (.clk(clk), .reset(reset), .d_i(bus.sensor_b), .q_o(b_sync));

    assign ab = {a_sync, b_sync};
`else
    // Sensors are already synchronous to clk.
    assign ab = {bus.sensor_a, bus.sensor_b};
`endif

    // Passage FSM with registered counter and event pulses; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (ab)
                        A_ONLY:  state_q <= EN_A;
                        B_ONLY:  state_q <= EX_B;
                        BOTH:    state_q <= ABORT;
                        default: ;
                    endcase
                end
                EN_A: begin
                    case (ab)
                        BOTH:    state_q <= EN_AB;
                        NONE:    state_q <= IDLE;   // backed out before reaching B
                        B_ONLY:  state_q <= ABORT;
                        default: ;
                    endcase
                end
                EN_AB: begin
                    case (ab)
                        B_ONLY:  state_q <= EN_B;
                        A_ONLY:  state_q <= EN_A;
                        NONE:    state_q <= ABORT;
                        default: ;
                    endcase
                end
                EN_B: begin
                    case (ab)
                        NONE: begin
                            state_q <= IDLE;
                            enter_q <= 1'b1;
                            // A full lot still reports the entry, but flags the lost count.
                            if (count_q < CAP_C) count_q <= count_q + CNT_W'(1);
                            else                 err_q   <= 1'b1;
                        end
                        BOTH:    state_q <= EN_AB;
                        A_ONLY:  state_q <= ABORT;
                        default: ;
                    endcase
                end
                EX_B: begin
                    case (ab)
                        BOTH:    state_q <= EX_BA;
                        NONE:    state_q <= IDLE;
                        A_ONLY:  state_q <= ABORT;
                        default: ;
                    endcase
                end
                EX_BA: begin
                    case (ab)
                        A_ONLY:  state_q <= EX_A;
                        B_ONLY:  state_q <= EX_B;
                        NONE:    state_q <= ABORT;
                        default: ;
                    endcase
                end
                EX_A: begin
                    case (ab)
                        NONE: begin
                            state_q <= IDLE;
                            exit_q  <= 1'b1;
                            if (count_q != '0) count_q <= count_q - CNT_W'(1);
                            else               err_q   <= 1'b1;
                        end
                        BOTH:    state_q <= EX_BA;
                        B_ONLY:  state_q <= ABORT;
                        default: ;
                    endcase
                end
                ABORT: begin
                    if (ab == NONE) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = (count_q == CAP_C);
    assign bus.empty     = (count_q == '0);
    assign bus.car_enter = enter_q;
    assign bus.car_exit  = exit_q;
    assign bus.count_err = err_q;
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Randomized and directed bench for parking_lot_ctrl against a position-walk reference model.
// Latency: follows SENSOR_SYNC_EN (0 or 2 extra cycles).
// Backpressure: n/a.
module tb_parking_lot_ctrl;
    localparam int CAP   = 16;
    localparam int CNT_W = 5;
`ifdef SENSOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic reset;

    parking_lot_ctrl_if #(.CNT_W(CNT_W)) bus ();

    parking_lot_ctrl #(.CAPACITY(CAP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests;
    int fails;
    bit chk_en;
    int en_seen;
    int ex_seen;
    int err_seen;

    // Reference model: car position along its passage (0 = clear, 1..3 = progressing).
    int         m_dir;     // 1 = entering, 2 = exiting
    int         m_pos;
    bit         m_abort;
    int         m_cnt;
    bit         m_en;
    bit         m_ex;
    bit         m_err;
    logic [1:0] pipe0;
    logic [1:0] pipe1;

    // Where a sensor pattern puts the car along its direction of travel.
    function automatic int pos_of(int dir, logic [1:0] s);
        if (s == 2'b00) return 0;
        if (s == 2'b11) return 2;
        if (dir == 1)   return (s == 2'b10) ? 1 : 3;
        return (s == 2'b01) ? 1 : 3;
    endfunction

    always @(posedge clk) begin
        logic [1:0] s;
        int np;
        m_en  = 1'b0;
        m_ex  = 1'b0;
        m_err = 1'b0;
        if (reset) begin
            m_dir = 0; m_pos = 0; m_abort = 1'b0; m_cnt = 0;
            pipe0 = 2'b00; pipe1 = 2'b00;
        end else begin
            if (LAT == 2) begin
                s = pipe1; pipe1 = pipe0; pipe0 = {bus.sensor_a, bus.sensor_b};
            end else begin
                s = {bus.sensor_a, bus.sensor_b};
            end
            if (m_abort) begin
                if (s == 2'b00) m_abort = 1'b0;
            end else if (m_pos == 0) begin
                if (s == 2'b10)      begin m_dir = 1; m_pos = 1; end
                else if (s == 2'b01) begin m_dir = 2; m_pos = 1; end
                else if (s == 2'b11) m_abort = 1'b1;
            end else begin
                np = pos_of(m_dir, s);
                if (np == 0) begin
                    if (m_pos == 3) begin
                        if (m_dir == 1) begin
                            m_en = 1'b1;
                            if (m_cnt < CAP) m_cnt++; else m_err = 1'b1;
                        end else begin
                            m_ex = 1'b1;
                            if (m_cnt > 0) m_cnt--; else m_err = 1'b1;
                        end
                    end else if (m_pos == 2) begin
                        m_abort = 1'b1;
                    end
                    m_pos = 0;
                end else if (np == m_pos + 1 || np == m_pos - 1) begin
                    m_pos = np;
                end else if (np != m_pos) begin
                    m_abort = 1'b1;
                    m_pos   = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge and check every output against the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("count",     32'(bus.count),     32'(m_cnt));
            chk("full",      32'(bus.full),      32'(m_cnt == CAP));
            chk("empty",     32'(bus.empty),     32'(m_cnt == 0));
            chk("car_enter", 32'(bus.car_enter), 32'(m_en));
            chk("car_exit",  32'(bus.car_exit),  32'(m_ex));
            chk("count_err", 32'(bus.count_err), 32'(m_err));
            en_seen  += int'(bus.car_enter);
            ex_seen  += int'(bus.car_exit);
            err_seen += int'(bus.count_err);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int n);
        repeat (n) begin
            tick();
            {bus.sensor_a, bus.sensor_b} = ab;
        end
    endtask

    task automatic settle();
        drive(2'b00, LAT + 3);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        {bus.sensor_a, bus.sensor_b} = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic entry();
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1); drive(2'b00, 1);
        settle();
    endtask

    task automatic exit_pass();
        drive(2'b01, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 1);
        settle();
    endtask

    task automatic rand_passage();
        logic [1:0] seq [4];
        int kind;
        int pos;
        int steps;
        kind = $urandom_range(0, 3);
        if (kind <= 1) begin
            if (kind == 0) begin
                seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01;
            end else begin
                seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
            end
            seq[3] = 2'b00;
            pos = 0;
            steps = 0;
            while (pos < 4 && steps < 20) begin
                drive(seq[pos], $urandom_range(1, 3));
                steps++;
                if (pos > 0 && pos < 3 && $urandom_range(0, 7) == 0) pos--;
                else pos++;
            end
            drive(2'b00, $urandom_range(1, 3));
        end else if (kind == 2) begin
            repeat ($urandom_range(1, 5)) drive(2'($urandom_range(0, 3)), $urandom_range(1, 3));
            drive(2'b00, $urandom_range(1, 3));
        end else begin
            if ($urandom_range(0, 9) == 0) do_reset();
            else drive(2'b00, $urandom_range(1, 4));
        end
    endtask

    int e0, x0, r0;

    initial begin
        tests = 0; fails = 0; chk_en = 1'b0;
        en_seen = 0; ex_seen = 0; err_seen = 0;
        reset = 1'b1;
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);

        // Single entry with latency check
        e0 = en_seen;
        drive(2'b00, 1); drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, 1); drive(2'b00, 1);
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("enter_early", 32'(bus.car_enter), 0);
        end
        tick();
        chk("enter_pulse", 32'(bus.car_enter), 1);
        chk("enter_count", 32'(bus.count), 1);
        chk("enter_empty", 32'(bus.empty), 0);
        tick();
        chk("enter_width", 32'(bus.car_enter), 0);
        settle();
        chk("enter_once", 32'(en_seen - e0), 1);

        // Single exit back to empty
        x0 = ex_seen;
        exit_pass();
        chk("exit_count", 32'(bus.count), 0);
        chk("exit_empty", 32'(bus.empty), 1);
        chk("exit_once",  32'(ex_seen - x0), 1);

        // Exit when already empty
        x0 = ex_seen; r0 = err_seen;
        exit_pass();
        chk("uflow_count", 32'(bus.count), 0);
        chk("uflow_exit",  32'(ex_seen - x0), 1);
        chk("uflow_err",   32'(err_seen - r0), 1);

        // Fill to capacity, then one more
        repeat (CAP) entry();
        chk("fill_count", 32'(bus.count), CAP);
        chk("fill_full",  32'(bus.full), 1);
        e0 = en_seen; r0 = err_seen;
        entry();
        chk("oflow_count", 32'(bus.count), CAP);
        chk("oflow_enter", 32'(en_seen - e0), 1);
        chk("oflow_err",   32'(err_seen - r0), 1);
        exit_pass();
        chk("drain_count", 32'(bus.count), CAP - 1);
        chk("drain_full",  32'(bus.full), 0);

        // Aborted and backed-out passages
        e0 = en_seen; x0 = ex_seen; r0 = err_seen;
        drive(2'b10, 1); drive(2'b00, 1); settle();
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 1); settle();
        drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 1); settle();
        drive(2'b10, 1); drive(2'b01, 1); drive(2'b00, 1); settle();
        chk("abort_count", 32'(bus.count), CAP - 1);
        chk("abort_events", 32'(en_seen - e0 + ex_seen - x0 + err_seen - r0), 0);

        // Reset mid-passage in EN_B with count 5
        do_reset();
        repeat (5) entry();
        chk("pre_rst_count", 32'(bus.count), 5);
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b01, LAT + 2);
        tick();
        reset = 1'b1;
        {bus.sensor_a, bus.sensor_b} = 2'b00;
        tick();
        reset = 1'b0;
        chk("midrst_count", 32'(bus.count), 0);
        chk("midrst_empty", 32'(bus.empty), 1);
        e0 = en_seen;
        settle();
        chk("midrst_noevent", 32'(en_seen - e0), 0);

        // Randomized passages against the model
        for (int i = 0; i < 400; i++) rand_passage();
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Sequencing controller for the parking-lot occupancy datapath. It watches two gate photosensors, A on the outer side and B on the inner side. It decodes complete enter and exit passages with a direction FSM and maintains a saturating occupancy count. The count drives the existing seven-segment occupancy display, which shows CLEAR at 0, FULL at CAPACITY, and the number otherwise. The block also reports full and empty status and single-cycle event pulses to the top level (gate LEDs).

## Interface
- CAPACITY, 16: maximum occupancy; count saturates here.
- CNT_W, 5: count width; must satisfy 2^CNT_W > CAPACITY.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high.
- sensor_a  input  1  outer sensor, 1 = beam blocked.
- sensor_b  input  1  inner sensor, 1 = beam blocked.
- count  output  CNT_W  current occupancy, 0..CAPACITY; feeds the display.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- car_enter  output  1  one-cycle pulse per completed entry.
- car_exit  output  1  one-cycle pulse per completed exit.
- count_err  output  1  one-cycle pulse when a passage completes but the count is already saturated (entry at full, exit at empty).

## Operation
- Sensor pair is written ab. In-state values not listed keep the current state.
- FSM states: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, ABORT.
- IDLE: 10 goes to EN_A; 01 goes to EX_B; 11 goes to ABORT.
- EN_A: 11 goes to EN_AB; 00 goes to IDLE (car backed out, no event); 01 goes to ABORT.
- EN_AB: 01 goes to EN_B; 10 goes to EN_A (backing up); 00 goes to ABORT.
- EN_B: 00 goes to IDLE and completes an entry; 11 goes to EN_AB; 10 goes to ABORT.
- Exit chain (EX_B, EX_BA, EX_A) mirrors the entry chain with a and b swapped. EX_A with 00 completes an exit.
- ABORT: stays until 00 is sampled, then goes to IDLE. No event is produced for an aborted passage.
- Entry completion:
  - If count < CAPACITY: count += 1, car_enter = 1.
  - Otherwise: count unchanged, car_enter = 1, count_err = 1.
- Exit completion:
  - If count > 0: count −= 1, car_exit = 1.
  - Otherwise: count unchanged, car_exit = 1, count_err = 1.
- Entry and exit completions are mutually exclusive because a single FSM handles both, so the counter never sees a simultaneous increment and decrement.
- full and empty are decoded from the count register; they carry no extra delay.

## Timing
- Reset:
  - state = IDLE, count = 0, empty = 1, full = 0.
  - All pulses are 0.
  - Synchronizer flops (when compiled in) are cleared to 0.
- Reset asserted mid-passage abandons the passage. The first sampled ab after reset is interpreted from IDLE.
- Latency, without SENSOR_SYNC_EN: if the completing 00 is sampled at edge N, the updated count and the event pulses are visible after edge N (registered outputs). Each pulse is high for exactly one cycle.
- With SENSOR_SYNC_EN: add 2 cycles of latency on every input-to-output path.
- Sensors holding any value indefinitely produce no further events. At most one event occurs per completed passage.

## Configuration
- Macro: SENSOR_SYNC_EN.
- Defined: sensor_a and sensor_b each pass through a two-flop synchronizer before the FSM; latency is as stated in Timing.
- Undefined: sensors feed the FSM directly. The caller guarantees they are synchronous to clk.

## Structure
- Package parking_pkg holds:
  - the state enum typedef (8 states, 3-bit encoding);
  - the default CAPACITY constant;
  - a localparam for the sensor pair encodings (A_ONLY = 2'b10, B_ONLY = 2'b01, BOTH = 2'b11, NONE = 2'b00).
- Sub-module sensor_sync is a generic two-flop synchronizer with synchronous active-high reset. It is instantiated once per sensor, only under SENSOR_SYNC_EN.
- The counter and the FSM stay in parking_lot_ctrl.

## Test plan
- Reset, then ab sequence 00,10,11,01,00 → one car_enter pulse, count 0→1, empty 1→0.
- From count 1, ab sequence 01,11,10,00 → one car_exit pulse, count 1→0, empty = 1.
- 16 entry passages, then a 17th → count stops at 16, full = 1 from the 16th entry; the 17th entry pulses car_enter and count_err with count held at 16. Then one exit → count 15, full = 0.
- Exit passage at count 0 → car_exit and count_err pulse, count stays 0.
- Aborted and backed-out passages produce no event and leave count unchanged:
  - 10,00;
  - 10,11,10,00;
  - 11,10,00 (via ABORT);
  - 10,01,00.
- Reset asserted while in EN_B with count 5 → next cycle count = 0 and state = IDLE. A following 00 generates no event. Repeat the first scenario with SENSOR_SYNC_EN defined and check the 2-cycle extra latency.
